// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit definitions: width defaults
// and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int PC_W_DEF    = 13;
  localparam int INSTR_W_DEF = 32;
  localparam int PC_STEP_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: small synchronous FIFO,
// flush overrides both push and pop.
module fetch_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && (r_count != CW'(DEPTH));

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // storage, written only on a real push
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  assign o_data  = (r_count == '0) ? '0 : r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: drives the pc register, issues
// imem reads and buffers words for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int INSTR_W    = INSTR_W_DEF,
  parameter int PC_STEP    = PC_STEP_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pcResult,
  output logic [PC_W-1:0]    pcNext,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = INSTR_W + PC_W;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [PC_W-1:0] r_saved_addr;
  logic            w_ack;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_valid;
  logic            w_room;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_cnt_after;
  logic [FW-1:0]   w_head;

  // an ack only counts while a request is out
  assign w_ack   = imem_ack && !reset &&
                   (r_state != IDLE);
  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid && instr_ready;
  assign w_push  = (r_state == REQ) && w_ack &&
                   !redirect;
  assign w_flush = reset || redirect;

  assign w_cnt_after = {1'b0, w_count}
                     + (CW+1)'(w_push)
                     - (CW+1)'(w_pop);
  assign w_room = w_cnt_after < (CW+1)'(FIFO_DEPTH);

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({imem_rdata, pcResult}),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign instr_valid        = w_valid;
  assign {instr, instr_pc}  = w_head;

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= REQ;
    else       r_state <= w_state_nxt;
  end

  // address of a request abandoned by redirect
  always_ff @(posedge clk) begin
    if (reset)
      r_saved_addr <= '0;
    else if (r_state == REQ && redirect && !w_ack)
      r_saved_addr <= pcResult;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (redirect || w_room) w_state_nxt = REQ;
      end
      REQ: begin
        if (redirect)
          w_state_nxt = w_ack ? REQ : DROP;
        else if (w_ack)
          w_state_nxt = w_room ? REQ : IDLE;
      end
      DROP: begin
        if (w_ack) w_state_nxt = REQ;
      end
      default: w_state_nxt = REQ;
    endcase
  end

  // request, address and pcNext outputs
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pcResult;
    if (!reset) begin
      unique case (r_state)
        REQ:  imem_req = 1'b1;
        DROP: begin
          imem_req  = 1'b1;
          imem_addr = r_saved_addr;
        end
        default: imem_req = 1'b0;
      endcase
    end
    if (reset)
      pcNext = '0;
    else if (redirect)
      pcNext = redirect_target & ~PC_W'(3);
    else if (r_state == REQ && imem_ack)
      pcNext = pcResult + PC_W'(PC_STEP);
    else
      pcNext = pcResult;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit
// against a behavioural fetch model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [12:0] pcResult;
  logic [12:0] pcNext;
  logic        imem_req;
  logic [12:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [12:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [12:0] instr_pc;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .pcResult        (pcResult),
    .pcNext          (pcNext),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the pc register this unit talks to
  always @(posedge clk) pcResult <= pcNext;

  typedef struct packed {
    logic [12:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        q_exp[$];
  int          total = 0;
  int          bad   = 0;

  // behavioural model state
  logic [12:0] m_pc      = '0;
  logic [12:0] m_saved   = '0;
  bit          m_req     = 0;
  bit          m_drop    = 0;
  int          m_cnt     = 0;
  bit          m_known   = 0;
  bit          m_aft_rst = 0;
  int          lat_left  = -1;

  function automatic logic [31:0] mem_word(logic [12:0] a);
    return {3'b101, a, 3'b011, a};
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // one clock of stimulus, checks and model update
  task automatic step(input bit rst, input bit rd,
                      input logic [12:0] tg,
                      input bit rdy, input int lat);
    bit          ack;
    bit          pop;
    int          after;
    logic [12:0] tga;
    logic [12:0] exp_next;
    tga = tg & ~13'd3;
    ack = 0;
    if (rst) begin
      ack = 1;
    end else if (m_req) begin
      if (lat_left < 0)
        lat_left = (lat < 0) ?
                   int'($urandom_range(0, 3)) : lat;
      ack = (lat_left == 0);
    end
    reset           = rst;
    redirect        = rd;
    redirect_target = tg;
    instr_ready     = rdy;
    imem_ack        = ack;
    imem_rdata      = rst ? 32'($urandom) :
                      mem_word(m_drop ? m_saved : m_pc);
    if (rst)
      exp_next = '0;
    else if (rd)
      exp_next = tga;
    else if (m_req && !m_drop && ack)
      exp_next = m_pc + 13'd4;
    else
      exp_next = m_pc;

    @(negedge clk);
    chk("pcNext", pcNext, exp_next);
    chk("imem_req", imem_req, !rst && m_req);
    if (!rst && m_req)
      chk("imem_addr", imem_addr,
          m_drop ? m_saved : m_pc);
    if (m_known)
      chk("instr_valid", instr_valid, m_cnt > 0);
    if (m_aft_rst) begin
      chk("instr_rst", instr, 0);
      chk("instr_pc_rst", instr_pc, 0);
    end

    @(posedge clk);
    if (rst) begin
      q_exp.delete();
      m_cnt     = 0;
      m_pc      = '0;
      m_req     = 1;
      m_drop    = 0;
      lat_left  = -1;
      m_known   = 1;
      m_aft_rst = 1;
    end else begin
      m_aft_rst = 0;
      if (ack) lat_left = -1;
      else if (lat_left > 0) lat_left--;
      pop = (m_cnt > 0) && rdy && !rd;
      if (rd) begin
        q_exp.delete();
        m_cnt = 0;
        if (m_req && !m_drop && !ack) begin
          m_drop  = 1;
          m_saved = m_pc;
        end else if (!(m_drop && !ack)) begin
          m_drop = 0;
          m_req  = 1;
        end
        m_pc = tga;
      end else if (m_drop) begin
        if (ack) m_drop = 0;
      end else begin
        after = m_cnt - int'(pop);
        if (m_req && ack) begin
          q_exp.push_back('{pc: m_pc,
                            data: mem_word(m_pc)});
          after++;
          m_pc = m_pc + 13'd4;
        end
        if (!m_req || ack) m_req = (after < 2);
        m_cnt = after;
      end
    end
    #1;
  endtask

  // monitor: compare each instruction decode takes
  always @(negedge clk) begin
    exp_t e;
    if (instr_valid === 1'b1 && instr_ready &&
        !redirect && !reset) begin
      if (q_exp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_empty actual=%h required=none",
                 instr_pc);
      end else begin
        e = q_exp.pop_front();
        chk("instr_pc", instr_pc, e.pc);
        chk("instr", instr, e.data);
      end
    end
  end

  initial begin
    bit          r;
    bit          d;
    bit          y;
    logic [12:0] t;
    reset           = 1'b1;
    redirect        = 1'b0;
    redirect_target = '0;
    instr_ready     = 1'b0;
    imem_ack        = 1'b0;
    imem_rdata      = '0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // zero-wait stream from 0
    repeat (6) step(0, 0, 0, 1, 0);
    // 3-cycle latency at 0x10
    step(0, 1, 13'h0010, 1, 0);
    repeat (5) step(0, 0, 0, 1, 3);
    // decode stalled: fill, idle, one pop
    repeat (5) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    // redirect while waiting at 0x40, 1 entry held
    step(0, 1, 13'h003C, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 3);
    step(0, 1, 13'h0123, 0, 3);
    repeat (6) step(0, 0, 0, 1, 0);
    // wrap-around at the top of the pc space
    step(0, 1, 13'h1FF8, 1, 0);
    repeat (4) step(0, 0, 0, 1, 0);
    // reset in REQ with an entry, ack during reset
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 3);
    step(1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 1, -1);
    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      d = ($urandom_range(0, 11) == 0);
      y = ($urandom_range(0, 9) < 7);
      t = 13'($urandom);
      step(r, d, t, y, -1);
    end
    step(0, 0, 0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
